// File: rtl/dht11_response_builder.sv
// dht11_response_builder
// Takes one-byte commands from the UART receive path, restarts a DHT11 read,
// waits for the 40-bit frame, verifies the checksum and returns a two-byte
// {code, value} response over a valid/ready handshake to the UART transmitter.
// All outputs are registered; the FSM and its outputs live in one always_ff.

module dht11_response_builder #(
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int RST_CYCLES     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_code,
    output logic       cmd_ready,
    output logic       sensor_rst,
    output logic       sensor_en,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_float,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_float,
    input  logic [7:0] checksum,
    input  logic       data_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_WAIT,
        S_CHECK,
        S_SEND_CODE,
        S_SEND_VALUE
    } state_t;

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);

    localparam logic [7:0] CMD_LAST_VALID = 8'h02;
    localparam logic [7:0] CODE_STATUS    = 8'h07;
    localparam logic [7:0] CODE_HUMIDITY  = 8'h08;
    localparam logic [7:0] CODE_TEMP      = 8'h09;
    localparam logic [7:0] CODE_FAULT     = 8'h1F;
    localparam logic [7:0] CODE_UNKNOWN   = 8'hFF;

    state_t            state_reg;
    logic [1:0]        cmd_sel_reg;      // only codes 0..2 ever reach CHECK
    logic [7:0]        resp_value_reg;   // second response byte, waits behind the code byte
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [RST_W-1:0]  rst_cnt_reg;
    logic [7:0]        frame_sum;

    // Checksum is the byte-wise sum of the four data bytes, wrapping at 8 bits.
    assign frame_sum = hum_int + hum_float + temp_int + temp_float;

    // Command/response FSM with registered handshake and sensor-control outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cmd_sel_reg    <= 2'd0;
            resp_value_reg <= 8'h00;
            wait_cnt_reg   <= '0;
            rst_cnt_reg    <= '0;
            cmd_ready      <= 1'b1;
            sensor_rst     <= 1'b0;
            sensor_en      <= 1'b0;
            tx_valid       <= 1'b0;
            tx_data        <= 8'h00;
            busy           <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_sel_reg <= cmd_code[1:0];
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        if (cmd_code > CMD_LAST_VALID) begin
                            // Unknown command: answer immediately without touching the sensor.
                            tx_data        <= CODE_UNKNOWN;
                            resp_value_reg <= 8'h00;
                            tx_valid       <= 1'b1;
                            state_reg      <= S_SEND_CODE;
                        end else begin
                            sensor_rst  <= 1'b1;
                            sensor_en   <= 1'b1;
                            rst_cnt_reg <= '0;
                            state_reg   <= S_RST;
                        end
                    end
                end

                S_RST: begin
                    if (rst_cnt_reg == RST_LAST) begin
                        sensor_rst   <= 1'b0;
                        wait_cnt_reg <= '0;
                        state_reg    <= S_WAIT;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + RST_W'(1);
                    end
                end

                S_WAIT: begin
                    // A completed frame takes priority over a timeout on the same cycle.
                    if (data_ready) begin
                        sensor_en <= 1'b0;
                        state_reg <= S_CHECK;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        sensor_en      <= 1'b0;
                        tx_data        <= CODE_FAULT;
                        resp_value_reg <= 8'h00;
                        tx_valid       <= 1'b1;
                        state_reg      <= S_SEND_CODE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end

                S_CHECK: begin
                    // Sensor bytes are captured here only; the response registers hold them.
                    tx_valid  <= 1'b1;
                    state_reg <= S_SEND_CODE;
                    if (frame_sum != checksum) begin
                        tx_data        <= CODE_FAULT;
                        resp_value_reg <= 8'h00;
                    end else begin
                        case (cmd_sel_reg)
                            2'd0: begin
                                tx_data        <= CODE_STATUS;
                                resp_value_reg <= 8'h00;
                            end
                            2'd1: begin
                                tx_data        <= CODE_TEMP;
                                resp_value_reg <= temp_int;
                            end
                            default: begin
                                tx_data        <= CODE_HUMIDITY;
                                resp_value_reg <= hum_int;
                            end
                        endcase
                    end
                end

                S_SEND_CODE: begin
                    if (tx_ready) begin
                        tx_data   <= resp_value_reg;
                        state_reg <= S_SEND_VALUE;
                    end
                end

                S_SEND_VALUE: begin
                    if (tx_ready) begin
                        tx_valid  <= 1'b0;
                        tx_data   <= 8'h00;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end

                default: begin
                    state_reg  <= S_IDLE;
                    cmd_ready  <= 1'b1;
                    sensor_rst <= 1'b0;
                    sensor_en  <= 1'b0;
                    tx_valid   <= 1'b0;
                    tx_data    <= 8'h00;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_response_builder.sv
// Testbench for dht11_response_builder: scenario tasks driving commands and
// sensor frames, checking responses against a behavioural response model.

module tb_dht11_response_builder;

    localparam int TIMEOUT = 100;
    localparam int RST_C   = 2;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       cmd_ready;
    logic       sensor_rst;
    logic       sensor_en;
    logic [7:0] hum_int;
    logic [7:0] hum_float;
    logic [7:0] temp_int;
    logic [7:0] temp_float;
    logic [7:0] checksum;
    logic       data_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    int errors = 0;
    int checks = 0;

    dht11_response_builder #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .RST_CYCLES    (RST_C)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ready (cmd_ready),
        .sensor_rst(sensor_rst),
        .sensor_en (sensor_en),
        .hum_int   (hum_int),
        .hum_float (hum_float),
        .temp_int  (temp_int),
        .temp_float(temp_float),
        .checksum  (checksum),
        .data_ready(data_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Response expected from the command, the frame and whether the sensor answered in time.
    function automatic logic [15:0] model_resp(input logic [7:0] code, input logic [7:0] hi,
                                               input logic [7:0] hf, input logic [7:0] ti,
                                               input logic [7:0] tf, input logic [7:0] ck,
                                               input bit timed_out);
        int s;
        s = (int'(hi) + int'(hf) + int'(ti) + int'(tf)) % 256;
        if (code > 8'h02) return 16'hFF00;
        if (timed_out) return 16'h1F00;
        if (s != int'(ck)) return 16'h1F00;
        if (code == 8'h00) return 16'h0700;
        if (code == 8'h01) return {8'h09, ti};
        return {8'h08, hi};
    endfunction

    // One full command transaction; delay<0 means the sensor never answers.
    task automatic run_cmd(input logic [7:0] code, input logic [7:0] hi, input logic [7:0] hf,
                           input logic [7:0] ti, input logic [7:0] tf, input logic [7:0] ck,
                           input int delay, input bit early, input int stall, input int hold,
                           input bit spam,
                           output logic [7:0] b0, output logic [7:0] b1, output int nbytes,
                           output int rst_pulses, output int proto_err,
                           output int wait_first, output int valid_first);
        int  wcycles = 0;
        int  hold_left;
        int  k = 0;
        bit  prev_stalled = 1'b0;
        bit  done = 1'b0;
        logic [7:0] prev_data = 8'h00;
        b0 = 8'h00; b1 = 8'h00; nbytes = 0; rst_pulses = 0; proto_err = 0;
        wait_first = -1; valid_first = -1;
        while (!cmd_ready && k < 20) begin tick; k++; end
        hum_int = hi; hum_float = hf; temp_int = ti; temp_float = tf; checksum = ck;
        data_ready = early; tx_ready = 1'b0;
        cmd_code = code; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        hold_left = hold;
        for (int i = 0; i < 600 && !done; i++) begin
            if (sensor_rst) rst_pulses++;
            if (cmd_ready || !busy) proto_err++;
            if (tx_valid && sensor_en) proto_err++;
            if (prev_stalled && (!tx_valid || tx_data !== prev_data)) proto_err++;
            if (sensor_en && !sensor_rst) begin
                if (wait_first < 0) wait_first = i;
                if (!data_ready) begin
                    wcycles++;
                    if (delay >= 0 && wcycles > delay) data_ready = 1'b1;
                end
            end
            if (tx_valid && valid_first < 0) valid_first = i;
            if (tx_valid && hold_left > 0) begin
                tx_ready = 1'b0;
                hold_left--;
            end else if (stall == 0) begin
                tx_ready = 1'b1;
            end else begin
                tx_ready = ($urandom_range(0, stall) == 0);
            end
            prev_stalled = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (tx_valid && tx_ready) begin
                if (nbytes == 0) b0 = tx_data; else b1 = tx_data;
                nbytes++;
            end
            if (nbytes == 2) done = 1'b1;
            if (spam && !done) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_code = 8'($urandom_range(0, 255));
            end else begin
                cmd_valid = 1'b0;
            end
            tick;
        end
        cmd_valid = 1'b0; tx_ready = 1'b0; data_ready = 1'b0;
        if (tx_valid || !cmd_ready || busy) proto_err++;
    endtask

    task automatic test_reset;
        reset = 1'b1; cmd_valid = 1'b0; cmd_code = 8'h00; data_ready = 1'b0; tx_ready = 1'b0;
        hum_int = 8'h00; hum_float = 8'h00; temp_int = 8'h00; temp_float = 8'h00; checksum = 8'h00;
        tick; tick; tick;
        reset = 1'b0;
        checks++;
        if ({cmd_ready, sensor_rst, sensor_en, tx_valid, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 10000", {cmd_ready, sensor_rst, sensor_en, tx_valid, busy});
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx_data: got %02h want 00", tx_data);
        end
        $display("txn reset: cmd_ready=%b tx_valid=%b tx_data=%02h", cmd_ready, tx_valid, tx_data);
    endtask

    task automatic test_temperature;
        logic [15:0] exp;
        int n = 0;
        exp = model_resp(8'h01, 8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 1'b0);
        hum_int = 8'h37; hum_float = 8'h00; temp_int = 8'h19; temp_float = 8'h05; checksum = 8'h55;
        data_ready = 1'b0; tx_ready = 1'b1;
        cmd_code = 8'h01; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        checks++;
        if ({sensor_rst, sensor_en, cmd_ready, busy} !== 4'b1101) begin
            errors++;
            $display("FAIL temp_rst_phase: got %b want 1101", {sensor_rst, sensor_en, cmd_ready, busy});
        end
        while (!(sensor_en && !sensor_rst) && n < 10) begin tick; n++; end
        checks++;
        if (!(sensor_en && !sensor_rst)) begin
            errors++;
            $display("FAIL temp_wait_entry: not in wait after %0d cycles", n);
        end
        data_ready = 1'b1;
        tick;
        checks++;
        if ({tx_valid, sensor_en} !== 2'b00) begin
            errors++;
            $display("FAIL temp_check_cycle: tx_valid/sensor_en got %b want 00", {tx_valid, sensor_en});
        end
        tick;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp[15:8]) begin
            errors++;
            $display("FAIL temp_code_byte: got v=%b %02h want v=1 %02h", tx_valid, tx_data, exp[15:8]);
        end
        tick;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp[7:0]) begin
            errors++;
            $display("FAIL temp_value_byte: got v=%b %02h want v=1 %02h", tx_valid, tx_data, exp[7:0]);
        end
        tick;
        checks++;
        if (tx_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL temp_back_idle: tx_valid=%b cmd_ready=%b want 0 1", tx_valid, cmd_ready);
        end
        data_ready = 1'b0; tx_ready = 1'b0;
        $display("txn temperature: cmd=01 exp=%04h", exp);
    endtask

    // Directed scenarios routed through run_cmd, each checked inline.
    task automatic test_scenarios;
        logic [7:0] b0, b1;
        logic [15:0] exp;
        int nb, rp, pe, wf, vf;

        // humidity with checksum error
        exp = model_resp(8'h02, 8'h37, 8'h00, 8'h19, 8'h05, 8'h54, 1'b0);
        run_cmd(8'h02, 8'h37, 8'h00, 8'h19, 8'h05, 8'h54, 3, 1'b0, 0, 0, 1'b0, b0, b1, nb, rp, pe, wf, vf);
        checks++;
        if (nb != 2 || {b0, b1} !== exp) begin
            errors++;
            $display("FAIL cksum_err_resp: got %0d bytes %02h%02h want %04h", nb, b0, b1, exp);
        end
        $display("txn cksum_err: cmd=02 resp=%02h%02h exp=%04h", b0, b1, exp);

        // timeout
        exp = model_resp(8'h00, 8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 1'b1);
        run_cmd(8'h00, 8'h37, 8'h00, 8'h19, 8'h05, 8'h55, -1, 1'b0, 0, 0, 1'b0, b0, b1, nb, rp, pe, wf, vf);
        checks++;
        if (nb != 2 || {b0, b1} !== exp) begin
            errors++;
            $display("FAIL timeout_resp: got %0d bytes %02h%02h want %04h", nb, b0, b1, exp);
        end
        checks++;
        if (wf < 0 || vf - wf != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_latency: tx_valid %0d cycles after wait entry, want %0d", vf - wf, TIMEOUT);
        end
        checks++;
        if (rp != RST_C || pe != 0) begin
            errors++;
            $display("FAIL timeout_rst_proto: rst_cycles=%0d proto_err=%0d want %0d 0", rp, pe, RST_C);
        end
        $display("txn timeout: cmd=00 resp=%02h%02h exp=%04h latency=%0d", b0, b1, exp, vf - wf);

        // unknown command
        exp = model_resp(8'hA5, 8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 1'b0);
        run_cmd(8'hA5, 8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 0, 1'b0, 0, 0, 1'b0, b0, b1, nb, rp, pe, wf, vf);
        checks++;
        if (nb != 2 || {b0, b1} !== exp || rp != 0) begin
            errors++;
            $display("FAIL unknown_cmd: got %0d bytes %02h%02h rst=%0d want %04h rst=0", nb, b0, b1, rp, exp);
        end
        $display("txn unknown: cmd=A5 resp=%02h%02h exp=%04h", b0, b1, exp);

        // backpressure: first byte held for 5 cycles
        exp = model_resp(8'h00, 8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 1'b0);
        run_cmd(8'h00, 8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 1, 1'b0, 0, 5, 1'b0, b0, b1, nb, rp, pe, wf, vf);
        checks++;
        if (nb != 2 || {b0, b1} !== exp || pe != 0) begin
            errors++;
            $display("FAIL backpressure: got %0d bytes %02h%02h proto_err=%0d want %04h 0", nb, b0, b1, pe, exp);
        end
        $display("txn backpressure: cmd=00 resp=%02h%02h exp=%04h", b0, b1, exp);

        // data_ready already high on wait entry
        exp = model_resp(8'h01, 8'h40, 8'h03, 8'h1A, 8'h07, 8'h64, 1'b0);
        run_cmd(8'h01, 8'h40, 8'h03, 8'h1A, 8'h07, 8'h64, 0, 1'b1, 0, 0, 1'b0, b0, b1, nb, rp, pe, wf, vf);
        checks++;
        if (nb != 2 || {b0, b1} !== exp || rp != RST_C) begin
            errors++;
            $display("FAIL early_ready: got %0d bytes %02h%02h rst=%0d want %04h", nb, b0, b1, rp, exp);
        end
        $display("txn early_ready: cmd=01 resp=%02h%02h exp=%04h", b0, b1, exp);

        // data_ready on the very cycle the timeout would fire
        exp = model_resp(8'h02, 8'h2D, 8'h01, 8'h16, 8'h02, 8'h46, 1'b0);
        run_cmd(8'h02, 8'h2D, 8'h01, 8'h16, 8'h02, 8'h46, TIMEOUT - 1, 1'b0, 0, 0, 1'b0, b0, b1, nb, rp, pe, wf, vf);
        checks++;
        if (nb != 2 || {b0, b1} !== exp) begin
            errors++;
            $display("FAIL ready_vs_timeout: got %0d bytes %02h%02h want %04h", nb, b0, b1, exp);
        end
        $display("txn ready_vs_timeout: cmd=02 resp=%02h%02h exp=%04h", b0, b1, exp);

        // data_ready one cycle too late
        exp = model_resp(8'h02, 8'h2D, 8'h01, 8'h16, 8'h02, 8'h46, 1'b1);
        run_cmd(8'h02, 8'h2D, 8'h01, 8'h16, 8'h02, 8'h46, TIMEOUT, 1'b0, 0, 0, 1'b0, b0, b1, nb, rp, pe, wf, vf);
        checks++;
        if (nb != 2 || {b0, b1} !== exp) begin
            errors++;
            $display("FAIL ready_too_late: got %0d bytes %02h%02h want %04h", nb, b0, b1, exp);
        end
        $display("txn ready_too_late: cmd=02 resp=%02h%02h exp=%04h", b0, b1, exp);
    endtask

    // Randomized back-to-back commands with stalls and commands spammed while busy.
    task automatic test_back_to_back;
        logic [7:0] code, hi, hf, ti, tf, ck, b0, b1;
        logic [15:0] exp;
        int nb, rp, pe, wf, vf, delay;
        bit early, spam;
        for (int t = 0; t < 30; t++) begin
            code  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(3, 255)) : 8'($urandom_range(0, 2));
            hi = 8'($urandom); hf = 8'($urandom); ti = 8'($urandom); tf = 8'($urandom);
            ck = ($urandom_range(0, 9) < 7) ? 8'(hi + hf + ti + tf) : 8'($urandom);
            delay = ($urandom_range(0, 14) == 0) ? -1 : int'($urandom_range(0, 20));
            early = ($urandom_range(0, 4) == 0);
            spam  = ($urandom_range(0, 1) == 1);
            exp = model_resp(code, hi, hf, ti, tf, ck, !early && delay < 0);
            run_cmd(code, hi, hf, ti, tf, ck, delay, early, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), spam, b0, b1, nb, rp, pe, wf, vf);
            checks++;
            if (nb != 2 || {b0, b1} !== exp) begin
                errors++;
                $display("FAIL rand_resp[%0d]: cmd=%02h got %0d bytes %02h%02h want %04h", t, code, nb, b0, b1, exp);
            end
            checks++;
            if (pe != 0 || rp != ((code <= 8'h02) ? RST_C : 0)) begin
                errors++;
                $display("FAIL rand_proto[%0d]: proto_err=%0d rst=%0d want 0 %0d", t, pe, rp,
                         (code <= 8'h02) ? RST_C : 0);
            end
            $display("txn rand[%0d]: cmd=%02h resp=%02h%02h exp=%04h", t, code, b0, b1, exp);
        end
    endtask

    task automatic test_reset_mid_transfer;
        int n = 0;
        int extra = 0;
        hum_int = 8'h37; hum_float = 8'h00; temp_int = 8'h19; temp_float = 8'h05; checksum = 8'h55;
        data_ready = 1'b1; tx_ready = 1'b0;
        cmd_code = 8'h01; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        while (!tx_valid && n < 20) begin tick; n++; end
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h09) begin
            errors++;
            $display("FAIL midrst_code: got v=%b %02h want v=1 09", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h19) begin
            errors++;
            $display("FAIL midrst_value: got v=%b %02h want v=1 19", tx_valid, tx_data);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        data_ready = 1'b0;
        checks++;
        if ({tx_valid, cmd_ready, busy, sensor_en} !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_after: tx_valid/cmd_ready/busy/sensor_en got %b want 0100",
                     {tx_valid, cmd_ready, busy, sensor_en});
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid) extra++;
            tick;
        end
        tx_ready = 1'b0;
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL midrst_no_bytes: %0d valid cycles after reset, want 0", extra);
        end
        $display("txn reset_mid_transfer: extra_valid=%0d", extra);
    endtask

    initial begin
        test_reset;
        test_temperature;
        test_scenarios;
        test_back_to_back;
        test_reset_mid_transfer;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
